mc_ctrl: RTL and testbench

Multi-cycle control unit for the CPU datapath: a Moore FSM that sequences PC, instruction memory, RegMUX, RegFile and ALU one instruction at a time. It decodes opcode/funct from the instruction register and drives every datapath enable and mux select, including `RegDst`, `RegWrite` and the 4-bit ALU operation. It stalls on a memory-ready handshake, traps on illegal instructions and counts retired instructions.

---
 rtl/mc_ctrl_if.sv | 47 ++++
 rtl/mc_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mc_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// Control-unit bundle between the multi-cycle controller and the datapath.
// The datapath (master) supplies the decoded instruction fields and the
// memory/ALU status. The controller (slave) returns every enable, every mux
// select and its debug view.
// Handshake: mem_ready is a level-sensitive completion flag. While the
// controller holds a memory strobe (mem_read/mem_write) in FETCH or MEM, an
// access completes on the first rising edge that sees mem_ready=1. The
// strobe stays high and stable until that edge. mem_ready is ignored in
// every other state.
interface mc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;

  logic             pc_write;
  logic [1:0]       pc_src;
  logic             ir_write;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [3:0]       alu_ctrl;
  logic             illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output opcode, funct, zero, mem_ready,
    input  pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl,
           illegal, state, instr_count
  );

  modport slave (
    input  opcode, funct, zero, mem_ready,
    output pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl,
           illegal, state, instr_count
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle Moore control unit. It steps one instruction at a time through
// FETCH/DECODE/EXEC/MEM/WB and drives every datapath enable and select.
// It stalls on mem_ready, parks in TRAP on an unsupported instruction and
// counts retired instructions.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input logic        clk,
  input logic        rst,
  mc_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic             retire;

  logic             is_rtype, is_lw, is_sw, is_beq, is_addi, is_j;
  logic             funct_ok;
  logic [3:0]       r_alu;

  logic             pc_write_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c;

  assign is_rtype = (bus.opcode == OP_RTYPE);
  assign is_lw    = (bus.opcode == OP_LW);
  assign is_sw    = (bus.opcode == OP_SW);
  assign is_beq   = (bus.opcode == OP_BEQ);
  assign is_addi  = (bus.opcode == OP_ADDI);
  assign is_j     = (bus.opcode == OP_J);

  // Map an R-type funct field to its ALU operation and flag unsupported ones.
  always_comb begin
    r_alu    = ALU_ADD;
    funct_ok = 1'b1;
    case (bus.funct)
      FN_ADD:  r_alu = ALU_ADD;
      FN_SUB:  r_alu = ALU_SUB;
      FN_AND:  r_alu = ALU_AND;
      FN_OR:   r_alu = ALU_OR;
      FN_SLT:  r_alu = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  // State register; reset wins over every transition, including TRAP.
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic and Moore outputs for the current state.
  always_comb begin
    state_d        = state_q;
    retire         = 1'b0;
    pc_write_c     = 1'b0;
    ir_write_c     = 1'b0;
    mem_read_c     = 1'b0;
    mem_write_c    = 1'b0;
    reg_write_c    = 1'b0;
    bus.pc_src     = 2'b00;
    bus.i_or_d     = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_ctrl   = ALU_AND;
    case (state_q)
      FETCH: begin
        mem_read_c    = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.alu_ctrl  = ALU_ADD;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        // ALU precomputes PC + (imm << 2) so beq has its target ready.
        bus.alu_src_b = 2'b11;
        bus.alu_ctrl  = ALU_ADD;
        if (is_j) begin
          pc_write_c = 1'b1;
          bus.pc_src = 2'b10;
          retire     = 1'b1;
          state_d    = FETCH;
        end else if ((is_rtype && funct_ok) || is_lw || is_sw || is_beq || is_addi) begin
          state_d = EXEC;
        end else begin
          state_d = TRAP;
        end
      end
      EXEC: begin
        bus.alu_src_a = 1'b1;
        if (is_rtype) begin
          bus.alu_src_b = 2'b00;
          bus.alu_ctrl  = r_alu;
          state_d       = WB;
        end else if (is_beq) begin
          bus.alu_src_b = 2'b00;
          bus.alu_ctrl  = ALU_SUB;
          bus.pc_src    = 2'b01;
          pc_write_c    = bus.zero;
          retire        = 1'b1;
          state_d       = FETCH;
        end else begin
          bus.alu_src_b = 2'b10;
          bus.alu_ctrl  = ALU_ADD;
          state_d       = is_addi ? WB : MEM;
        end
      end
      MEM: begin
        bus.i_or_d  = 1'b1;
        mem_read_c  = is_lw;
        mem_write_c = is_sw;
        if (bus.mem_ready) begin
          if (is_sw) begin
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        reg_write_c    = 1'b1;
        bus.reg_dst    = is_rtype;
        bus.mem_to_reg = is_lw;
        retire         = 1'b1;
        state_d        = FETCH;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = TRAP;
      end
    endcase
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst)         count_q <= '0;
    else if (retire) count_q <= count_q + 1'b1;
  end

  // Strobes are suppressed while reset is held so nothing fires mid-reset.
  assign bus.pc_write    = pc_write_c  & ~rst;
  assign bus.ir_write    = ir_write_c  & ~rst;
  assign bus.mem_read    = mem_read_c  & ~rst;
  assign bus.mem_write   = mem_write_c & ~rst;
  assign bus.reg_write   = reg_write_c & ~rst;
  assign bus.illegal     = (state_q == TRAP);
  assign bus.state       = state_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl. A linear script of instructions is applied,
// and the hand-derived state/outputs are checked a short delay after each
// rising edge.
module tb_mc_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [31:0] exp_cnt;

  mc_ctrl_if #(.CNT_W(32)) bus ();

  mc_ctrl #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] strobes();
    return {27'd0, bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write};
  endfunction

  // Run one R-type instruction with mem_ready=1 and check every stage.
  task automatic run_rtype(input logic [5:0] fn, input logic [3:0] alu, input string tag);
    bus.opcode = 6'b000000; bus.funct = fn; bus.mem_ready = 1'b1; #1;
    chk({tag, "_f_state"}, bus.state, 0);
    chk({tag, "_f_irw"}, bus.ir_write, 1);
    chk({tag, "_f_pcw"}, bus.pc_write, 1);
    chk({tag, "_f_srcb"}, bus.alu_src_b, 2'b01);
    step();
    chk({tag, "_d_state"}, bus.state, 1);
    chk({tag, "_d_srcb"}, bus.alu_src_b, 2'b11);
    chk({tag, "_d_pcw"}, bus.pc_write, 0);
    step();
    chk({tag, "_e_state"}, bus.state, 2);
    chk({tag, "_e_srca"}, bus.alu_src_a, 1);
    chk({tag, "_e_srcb"}, bus.alu_src_b, 2'b00);
    chk({tag, "_e_alu"}, bus.alu_ctrl, alu);
    step();
    chk({tag, "_wb_state"}, bus.state, 4);
    chk({tag, "_wb_regw"}, bus.reg_write, 1);
    chk({tag, "_wb_regdst"}, bus.reg_dst, 1);
    chk({tag, "_wb_m2r"}, bus.mem_to_reg, 0);
    chk({tag, "_wb_cnt"}, bus.instr_count, exp_cnt);
    step();
    exp_cnt = exp_cnt + 1;
    chk({tag, "_done_state"}, bus.state, 0);
    chk({tag, "_done_cnt"}, bus.instr_count, exp_cnt);
  endtask

  // Directed sequence.
  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 0;
    rst = 1'b1;
    bus.opcode = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    step();
    step();
    chk("rst_state", bus.state, 0);
    chk("rst_cnt", bus.instr_count, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_strobes", strobes(), 0);
    rst = 1'b0;

    // R-type group: add, sub, and, or, slt.
    run_rtype(6'b100000, 4'b0010, "add");
    run_rtype(6'b100010, 4'b0110, "sub");
    run_rtype(6'b100100, 4'b0000, "and");
    run_rtype(6'b100101, 4'b0001, "or");
    run_rtype(6'b101010, 4'b0111, "slt");

    // lw with three wait cycles in MEM; mem_ready low in DECODE/EXEC is ignored.
    bus.opcode = 6'b100011; bus.mem_ready = 1'b1; #1;
    chk("lw_f_state", bus.state, 0);
    step();
    bus.mem_ready = 1'b0;
    chk("lw_d_state", bus.state, 1);
    step();
    chk("lw_e_state", bus.state, 2);
    chk("lw_e_srcb", bus.alu_src_b, 2'b10);
    chk("lw_e_alu", bus.alu_ctrl, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) bus.mem_ready = 1'b1;
      chk("lw_m_state", bus.state, 3);
      chk("lw_m_read", bus.mem_read, 1);
      chk("lw_m_iord", bus.i_or_d, 1);
      chk("lw_m_write", bus.mem_write, 0);
    end
    step();
    chk("lw_wb_state", bus.state, 4);
    chk("lw_wb_m2r", bus.mem_to_reg, 1);
    chk("lw_wb_regdst", bus.reg_dst, 0);
    chk("lw_wb_regw", bus.reg_write, 1);
    step();
    exp_cnt = exp_cnt + 1;
    chk("lw_done_state", bus.state, 0);
    chk("lw_done_cnt", bus.instr_count, exp_cnt);

    // beq taken then not taken.
    bus.opcode = 6'b000100; bus.zero = 1'b1;
    step(); step();
    chk("beq1_e_state", bus.state, 2);
    chk("beq1_e_pcw", bus.pc_write, 1);
    chk("beq1_e_pcsrc", bus.pc_src, 2'b01);
    chk("beq1_e_alu", bus.alu_ctrl, 4'b0110);
    step();
    exp_cnt = exp_cnt + 1;
    chk("beq1_done_state", bus.state, 0);
    bus.zero = 1'b0;
    step(); step();
    chk("beq0_e_state", bus.state, 2);
    chk("beq0_e_pcw", bus.pc_write, 0);
    step();
    exp_cnt = exp_cnt + 1;
    chk("beq0_done_state", bus.state, 0);
    chk("beq_cnt", bus.instr_count, exp_cnt);

    // j completes in two cycles.
    bus.opcode = 6'b000010;
    step();
    chk("j_d_state", bus.state, 1);
    chk("j_d_pcw", bus.pc_write, 1);
    chk("j_d_pcsrc", bus.pc_src, 2'b10);
    step();
    exp_cnt = exp_cnt + 1;
    chk("j_done_state", bus.state, 0);
    chk("j_cnt", bus.instr_count, exp_cnt);

    // addi: immediate operand, writes rt.
    bus.opcode = 6'b001000;
    step(); step();
    chk("addi_e_srcb", bus.alu_src_b, 2'b10);
    step();
    chk("addi_wb_state", bus.state, 4);
    chk("addi_wb_regdst", bus.reg_dst, 0);
    chk("addi_wb_regw", bus.reg_write, 1);
    step();
    exp_cnt = exp_cnt + 1;
    chk("addi_cnt", bus.instr_count, exp_cnt);

    // FETCH stall, then an illegal opcode.
    bus.opcode = 6'b111111; bus.mem_ready = 1'b0; #1;
    chk("stall_irw", bus.ir_write, 0);
    chk("stall_read", bus.mem_read, 1);
    step();
    chk("stall_state", bus.state, 0);
    bus.mem_ready = 1'b1;
    step();
    chk("ill_d_state", bus.state, 1);
    step();
    chk("ill_state", bus.state, 7);
    chk("ill_flag", bus.illegal, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("trap_strobes", strobes(), 0);
      chk("trap_state", bus.state, 7);
    end
    chk("trap_cnt", bus.instr_count, exp_cnt);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 0;
    chk("trap_rst_state", bus.state, 0);
    chk("trap_rst_illegal", bus.illegal, 0);
    chk("trap_rst_cnt", bus.instr_count, exp_cnt);

    // R-type with an unsupported funct also traps.
    bus.opcode = 6'b000000; bus.funct = 6'b100001;
    step(); step();
    chk("badfn_state", bus.state, 7);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Retire one addi so the reset below must clear a nonzero counter.
    bus.opcode = 6'b001000;
    step(); step(); step(); step();
    exp_cnt = exp_cnt + 1;
    chk("pre_sw_cnt", bus.instr_count, exp_cnt);

    // Reset during an sw MEM wait.
    bus.opcode = 6'b101011;
    step(); step();
    bus.mem_ready = 1'b0;
    step();
    chk("sw_m_state", bus.state, 3);
    chk("sw_m_write", bus.mem_write, 1);
    chk("sw_m_read", bus.mem_read, 0);
    step();
    chk("sw_m_hold", bus.state, 3);
    rst = 1'b1; #1;
    chk("sw_rst_write_now", bus.mem_write, 0);
    step();
    chk("sw_rst_state", bus.state, 0);
    chk("sw_rst_write", bus.mem_write, 0);
    chk("sw_rst_cnt", bus.instr_count, 0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
